// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller: funct3 size codes, FSM states,
// lane constants and the load lane-select/extension helper.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int         LANES   = 4;
  localparam int         LANE_W  = 8;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Picks the addressed lane out of a full word and sign/zero extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: LANE_W];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'b0, b};
      F3_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if;
  // A request transfers on a rising edge where req_valid and req_ready are both
  // high; rsp_valid is a single-cycle strobe with no backpressure.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// Four byte-wide memory lanes with per-lane write enable and a registered read.
module dmem_bank #(
  parameter int  MEM_SIZE = 1024,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] idx_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [MEM_SIZE];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en_i) begin
        if (be_i[l]) mem_q[idx_i] <= wdata_i[8*l +: 8];
        rd_q <= mem_q[idx_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: IDLE/ACCESS/RESP sequencer around dmem_bank.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE    = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_ctrl_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] RESP   = ST_RESP;
  localparam int         AW     = $clog2(MEM_SIZE);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;

  logic        accept, do_op;
  logic        f3_bad, range_bad, misalign, err;
  logic [3:0]  be;
  logic [31:0] wlane, bank_rdata;

  assign bus.req_ready = !reset && (state_q == IDLE || state_q == RESP);
  assign accept        = bus.req_valid && bus.req_ready;
  assign do_op         = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    f3_bad = 1'b1;
    case (f3_q)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = we_q;
      default:          f3_bad = 1'b1;
    endcase
  end

  assign range_bad = addr_q[31:2] >= 30'(MEM_SIZE);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                    (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign err = f3_bad || range_bad || misalign;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = BE_WORD;
    wlane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = BE_BYTE << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? (BE_HALF << 2) : BE_HALF;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = BE_WORD;
        wlane = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = ACCESS;
          cnt_d   = WS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      f3_q    <= bus.req_funct3;
      wdata_q <= bus.req_wdata;
    end
  end

  dmem_bank #(.MEM_SIZE(MEM_SIZE)) u_bank (
    .clk     (clk),
    .en_i    (do_op && !reset),
    .idx_i   (addr_q[AW+1:2]),
    .be_i    ((we_q && !err) ? be : 4'b0000),
    .wdata_i (wlane),
    .rdata_o (bank_rdata)
  );

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = bus.rsp_valid && err;
  assign bus.rsp_rdata = (bus.rsp_valid && !err && !we_q) ?
                         load_extend(bank_rdata, f3_q, addr_q[1:0]) : 32'd0;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, memory depth in 32-bit words, a power of two from 4 to 65536.
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra access cycles per request, 0..15.
REQ-003 SHALL have clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have reset  in  1  reset; reset is synchronous and active-high.
REQ-005 SHALL have req_valid  in  1  request present.
REQ-006 SHALL have req_ready  out  1  request accepted when high together with req_valid.
REQ-007 SHALL have req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have req_addr  in  32  byte address.
REQ-009 SHALL have req_funct3  in  3  RISC-V load/store size code.
REQ-010 SHALL have req_wdata  in  32  store data, LSB-aligned.
REQ-011 SHALL have rsp_valid  out  1  one-cycle response strobe; no backpressure.
REQ-012 SHALL have rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have rsp_err  out  1  request was illegal, misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-015 SHALL drive req_ready = 1 in IDLE and RESP, 0 in ACCESS and while reset is high.
REQ-016 SHALL, on an accept edge, latch we/addr/funct3/wdata, load the wait counter with WAIT_STATES and enter ACCESS.
REQ-017 SHALL hold ACCESS for WAIT_STATES+1 cycles, decrementing the counter each cycle.
REQ-018 SHALL perform the memory read/write on the final ACCESS edge, then enter RESP.
REQ-019 SHALL assert rsp_valid for exactly one cycle in RESP; latency from accept edge to rsp_valid high = WAIT_STATES+2 cycles.
REQ-020 SHALL, in RESP, accept a new request (to ACCESS) or go to IDLE; back-to-back requests lose no cycle.
REQ-021 SHALL decode funct3 as: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned (100/101 loads only).
REQ-022 SHALL flag rsp_err, suppress any write and return 0 for an undefined funct3 or a store with funct3 100/101.
REQ-023 SHALL flag rsp_err, suppress any write and return 0 when req_addr[31:2] >= MEM_SIZE.
REQ-024 SHALL select the load lane from addr[1:0] (byte) or addr[1] (half) and sign- or zero-extend it to 32 bits.
REQ-025 SHALL write stores through byte enables: byte writes one lane, half two lanes, word four lanes; other lanes keep their contents.
REQ-026 SHALL make a store visible to any request accepted afterwards, including one accepted in the store's RESP cycle.

Reset
REQ-027 SHALL, on a reset edge, go to IDLE, clear the wait counter and force rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-028 SHALL not write memory on any edge where reset is high; an in-flight request is dropped with no response.
REQ-029 SHALL not reset or initialise memory contents.

Configuration
REQ-030 SHALL, with DMEM_MISALIGN_TRAP_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as misaligned: rsp_err=1, no write, rdata 0.
REQ-031 SHALL, without DMEM_MISALIGN_TRAP_EN, ignore the offending low address bits (force alignment) and raise rsp_err only under REQ-022/REQ-023.

Structure
REQ-032 SHALL place the funct3 size enum, the FSM state enum and the lane/extension constants in package dmem_pkg.
REQ-033 SHALL instantiate sub-module dmem_bank: four byte-wide MEM_SIZE-deep arrays with per-lane write enable and a registered read.

Verification
REQ-034 SHALL check, with WAIT_STATES=0: SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-035 SHALL check: SB 0x80 to 0x13 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80000000.
REQ-036 SHALL check, with WAIT_STATES=3: back-to-back requests -> rsp_valid every 5 cycles, req_ready low exactly 4 cycles per request.
REQ-037 SHALL check: LH 0x11 -> rsp_err=1 and rdata=0 with macro defined; without macro, rsp_err=0 and the data returned equals LH 0x10.
REQ-038 SHALL check: SW to word index MEM_SIZE -> rsp_err=1 and index 0 unchanged; funct3 011 -> rsp_err=1.
REQ-039 SHALL check: reset asserted in the first ACCESS cycle of an SW with WAIT_STATES=2 -> no rsp_valid, memory unchanged, req_ready=1 on the first cycle after reset.
